// File: rtl/frame_sequencer_pkg.sv
// rtl/frame_sequencer_pkg.sv - shared types and widths for the frame sequencer
package frame_sequencer_pkg;

    localparam int STATE_WIDTH      = 2;
    localparam int PAGE_COUNT_WIDTH = 8;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_WAIT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_ADVANCE = 2'd2
    } seq_state_t;

    // A programmed page count of zero behaves as a single page.
    function automatic logic [PAGE_COUNT_WIDTH-1:0] effective_page_count(
        input logic [PAGE_COUNT_WIDTH-1:0] page_count
    );
        return (page_count == '0) ? {{(PAGE_COUNT_WIDTH-1){1'b0}}, 1'b1} : page_count;
    endfunction

endpackage

// File: rtl/frame_sequencer_if.sv
// rtl/frame_sequencer_if.sv - start/done handshake and per-channel frame addressing
interface frame_sequencer_if
    import frame_sequencer_pkg::*;
#(
    parameter int OUTPUT_COUNT      = 3,
    parameter int ADDRESS_BUS_WIDTH = 16
);

    logic [OUTPUT_COUNT-1:0]                   channel_start;
    logic [OUTPUT_COUNT-1:0]                   channel_done;
    logic [OUTPUT_COUNT*ADDRESS_BUS_WIDTH-1:0] start_addresses;
    logic [OUTPUT_COUNT*PAGE_COUNT_WIDTH-1:0]  page_indices;

    modport master (
        output channel_start,
        output start_addresses,
        output page_indices,
        input  channel_done
    );

    modport slave (
        input  channel_start,
        input  start_addresses,
        input  page_indices,
        output channel_done
    );

endinterface

// File: rtl/channel_page_tracker.sv
// rtl/channel_page_tracker.sv - per-channel page index and word offset with wrap
module channel_page_tracker
    import frame_sequencer_pkg::*;
#(
    parameter int ADDRESS_BUS_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sync,
    input  logic                         advance,
    input  logic [ADDRESS_BUS_WIDTH-1:0] word_count,
    input  logic [PAGE_COUNT_WIDTH-1:0]  page_count,
    output logic [PAGE_COUNT_WIDTH-1:0]  page_index,
    output logic [ADDRESS_BUS_WIDTH-1:0] page_offset
);

    logic [PAGE_COUNT_WIDTH:0] next_index;
    logic                      wrap;

    // One extra bit so index 255 + 1 still compares correctly against the count.
    assign next_index = {1'b0, page_index} + {{PAGE_COUNT_WIDTH{1'b0}}, 1'b1};
    assign wrap       = next_index >= {1'b0, effective_page_count(page_count)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            page_index  <= '0;
            page_offset <= '0;
        end else if (sync) begin
            page_index  <= '0;
            page_offset <= '0;
        end else if (advance) begin
            if (wrap) begin
                page_index  <= '0;
                page_offset <= '0;
            end else begin
                page_index  <= next_index[PAGE_COUNT_WIDTH-1:0];
                page_offset <= page_offset + word_count;
            end
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - frame pacing timer, start/done FSM and overrun tracking
module frame_sequencer
    import frame_sequencer_pkg::*;
#(
    parameter int OUTPUT_COUNT      = 3,
    parameter int ADDRESS_BUS_WIDTH = 16,
    parameter int PERIOD_WIDTH      = 24
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [PERIOD_WIDTH-1:0]                   frame_period,
    input  logic [OUTPUT_COUNT-1:0]                   enable_mask,
    input  logic                                      sync,
    input  logic [OUTPUT_COUNT*ADDRESS_BUS_WIDTH-1:0] base_addresses,
    input  logic [OUTPUT_COUNT*ADDRESS_BUS_WIDTH-1:0] word_counts,
    input  logic [OUTPUT_COUNT*PAGE_COUNT_WIDTH-1:0]  page_counts,
    frame_sequencer_if.master                         chan,
    output logic [7:0]                                overrun_count,
    output logic [STATE_WIDTH-1:0]                    state
);

    localparam logic [PERIOD_WIDTH-1:0] TIMER_ONE = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};

    seq_state_t                       cur_state;
    seq_state_t                       next_state;
    logic [PERIOD_WIDTH-1:0]          timer;
    logic [OUTPUT_COUNT-1:0]          active;
    logic [OUTPUT_COUNT-1:0]          pending;
    logic [OUTPUT_COUNT-1:0]          pending_cleared;
    logic [OUTPUT_COUNT-1:0]          start_q;
    logic                             skip_advance;
    logic                             free_run;
    logic                             expiry;
    logic                             launch;
    logic                             in_wait;
    logic                             in_run;
    logic                             in_advance;
    logic [ADDRESS_BUS_WIDTH-1:0]     page_offset [OUTPUT_COUNT];
    logic [PAGE_COUNT_WIDTH-1:0]      page_index  [OUTPUT_COUNT];

    assign free_run        = (frame_period == '0);
    // sync restarts the timer, so it also swallows an expiry landing in the same cycle
    assign expiry          = !free_run && !sync && (timer == frame_period - TIMER_ONE);
    assign pending_cleared = pending & ~chan.channel_done;
    assign launch          = in_wait && (expiry || free_run) && (enable_mask != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= ST_WAIT;
        end else begin
            cur_state <= next_state;
        end
    end

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            ST_WAIT:    if (launch) next_state = ST_RUN;
            ST_RUN:     if (pending_cleared == '0) next_state = ST_ADVANCE;
            ST_ADVANCE: next_state = ST_WAIT;
            default:    next_state = ST_WAIT;
        endcase
    end

    always_comb begin
        in_wait            = (cur_state == ST_WAIT);
        in_run             = (cur_state == ST_RUN);
        in_advance         = (cur_state == ST_ADVANCE);
        state              = cur_state;
        chan.channel_start = start_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer         <= '0;
            active        <= '0;
            pending       <= '0;
            start_q       <= '0;
            overrun_count <= '0;
            skip_advance  <= 1'b0;
        end else begin
            timer   <= (sync || expiry) ? '0 : timer + TIMER_ONE;
            start_q <= launch ? enable_mask : '0;

            if (launch) begin
                active  <= enable_mask;
                pending <= enable_mask;
            end else if (in_run) begin
                pending <= pending_cleared;
            end

            if (expiry && !in_wait && overrun_count != 8'hFF) begin
                overrun_count <= overrun_count + 8'd1;
            end

            // A sync during the frame already zeroed the pages; don't step past zero.
            if (in_advance) begin
                skip_advance <= 1'b0;
            end else if (sync && in_run) begin
                skip_advance <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < OUTPUT_COUNT; i++) begin : g_channel
        channel_page_tracker #(
            .ADDRESS_BUS_WIDTH(ADDRESS_BUS_WIDTH)
        ) u_tracker (
            .clk         (clk),
            .rst         (rst),
            .sync        (sync),
            .advance     (in_advance && active[i] && !skip_advance),
            .word_count  (word_counts[i*ADDRESS_BUS_WIDTH +: ADDRESS_BUS_WIDTH]),
            .page_count  (page_counts[i*PAGE_COUNT_WIDTH +: PAGE_COUNT_WIDTH]),
            .page_index  (page_index[i]),
            .page_offset (page_offset[i])
        );

        assign chan.start_addresses[i*ADDRESS_BUS_WIDTH +: ADDRESS_BUS_WIDTH] =
            base_addresses[i*ADDRESS_BUS_WIDTH +: ADDRESS_BUS_WIDTH] + page_offset[i];
        assign chan.page_indices[i*PAGE_COUNT_WIDTH +: PAGE_COUNT_WIDTH] = page_index[i];
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - self-checking bench for frame_sequencer
module tb_frame_sequencer;
    import frame_sequencer_pkg::*;

    localparam int OC = 3;
    localparam int AW = 16;
    localparam int PW = 24;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [PW-1:0]      frame_period = '0;
    logic [OC-1:0]      enable_mask = '0;
    logic               sync = 1'b0;
    logic [OC*AW-1:0]   base_addresses = '0;
    logic [OC*AW-1:0]   word_counts = '0;
    logic [OC*8-1:0]    page_counts = '0;
    logic [7:0]         overrun_count;
    logic [1:0]         state;

    frame_sequencer_if #(.OUTPUT_COUNT(OC), .ADDRESS_BUS_WIDTH(AW)) chan_if ();

    frame_sequencer #(
        .OUTPUT_COUNT(OC), .ADDRESS_BUS_WIDTH(AW), .PERIOD_WIDTH(PW)
    ) dut (
        .clk(clk), .rst(rst), .frame_period(frame_period), .enable_mask(enable_mask),
        .sync(sync), .base_addresses(base_addresses), .word_counts(word_counts),
        .page_counts(page_counts), .chan(chan_if), .overrun_count(overrun_count),
        .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int base_m[OC];
    int wc_m[OC];
    int pc_m[OC];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int t);
        while (cyc < t) tick();
    endtask

    task automatic load_cfg();
        for (int i = 0; i < OC; i++) begin
            base_addresses[i*AW +: AW] = base_m[i][AW-1:0];
            word_counts[i*AW +: AW]    = wc_m[i][AW-1:0];
            page_counts[i*8 +: 8]      = pc_m[i][7:0];
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sync = 1'b0;
        chan_if.channel_done = '0;
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    function automatic logic [AW-1:0] exp_addr(input int i, input int page);
        logic [31:0] s;
        s = base_m[i] + page * wc_m[i];
        return s[AW-1:0];
    endfunction

    // Schedule model: expiries fall at k*P-1, a frame occupies [start, last done + 1],
    // a start follows the first expiry seen idle (or last done + 3 in free-run).
    task automatic run_scenario(input int period, input logic [OC-1:0] mask,
                                input int d0, input int d1, input int d2, input int ncyc);
        int delay[OC];
        int ps[OC];
        int done_at[OC];
        int next_start, cur_s, last, md, exp_ovr, exp_state;
        logic [OC-1:0] exp_start;
        logic [OC*AW-1:0] ea;
        logic [OC*8-1:0] ep;
        logic [OC-1:0] d;
        delay[0] = d0; delay[1] = d1; delay[2] = d2;
        frame_period = PW'(period);
        enable_mask = mask;
        load_cfg();
        do_reset();
        for (int i = 0; i < OC; i++) begin ps[i] = 0; done_at[i] = -10; end
        cur_s = 1 << 30;
        last = -10;
        exp_ovr = 0;
        next_start = (mask == '0) ? -1 : ((period == 0) ? 1 : period);
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) tick();
            if (c == last + 2) begin
                for (int i = 0; i < OC; i++)
                    if (mask[i]) ps[i] = (ps[i] + 1) % ((pc_m[i] == 0) ? 1 : pc_m[i]);
            end
            if (period != 0 && c > 0 && (c % period) == 0 && (c - 1) >= cur_s
                && (c - 1) <= last + 1 && exp_ovr < 255)
                exp_ovr++;
            if (c == next_start) begin
                cur_s = c;
                md = 0;
                for (int i = 0; i < OC; i++) begin
                    if (mask[i]) begin
                        done_at[i] = c + delay[i];
                        if (delay[i] > md) md = delay[i];
                    end
                end
                last = c + md;
                next_start = (period == 0) ? last + 3
                                           : ((last + 3 + period - 1) / period) * period;
            end
            exp_start = (c == cur_s) ? mask : '0;
            exp_state = (c >= cur_s && c <= last) ? 1 : ((c == last + 1) ? 2 : 0);
            for (int i = 0; i < OC; i++) begin
                ea[i*AW +: AW] = exp_addr(i, ps[i]);
                ep[i*8 +: 8] = 8'(ps[i]);
            end
            check($sformatf("start@%0d", c), 64'(chan_if.channel_start), 64'(exp_start));
            check($sformatf("state@%0d", c), 64'(state), 64'(exp_state));
            check($sformatf("overrun@%0d", c), 64'(overrun_count), 64'(exp_ovr));
            check($sformatf("page_idx@%0d", c), 64'(chan_if.page_indices), 64'(ep));
            check($sformatf("addr@%0d", c), 64'(chan_if.start_addresses), 64'(ea));
            for (int i = 0; i < OC; i++) begin
                if (mask[i])
                    d[i] = (c == done_at[i]) ||
                           (($urandom % 6) == 0 && !(c >= cur_s && c <= done_at[i]));
                else
                    d[i] = (($urandom % 4) == 0);
            end
            chan_if.channel_done = d;
        end
        chan_if.channel_done = '0;
    endtask

    initial begin
        chan_if.channel_done = '0;

        // 100-cycle period, three channels, ch0 cycles through three pages
        base_m[0] = 32'h0100; wc_m[0] = 32'h40; pc_m[0] = 3;
        for (int i = 1; i < OC; i++) begin
            base_m[i] = int'($urandom % 65536); wc_m[i] = int'($urandom % 65536);
            pc_m[i] = int'($urandom % 5);
        end
        run_scenario(100, 3'b111, 20, 20, 20, 420);
        check("tp1_ch0_addr_frame4", 64'(chan_if.start_addresses[15:0]), 64'h0100);
        check("tp1_no_overrun", 64'(overrun_count), 64'd0);

        // long-running ch1 against a 50-cycle period
        run_scenario(50, 3'b010, 5, 120, 5, 250);
        check("tp3_overrun", 64'(overrun_count), 64'd2);

        // free-run
        run_scenario(0, 3'b111, 10, 10, 10, 80);

        // randomized configurations
        for (int r = 0; r < 6; r++) begin
            int per;
            per = (($urandom % 4) == 0) ? 0 : int'($urandom_range(20, 80));
            for (int i = 0; i < OC; i++) begin
                base_m[i] = int'($urandom % 65536); wc_m[i] = int'($urandom % 65536);
                pc_m[i] = int'($urandom % 5);
            end
            run_scenario(per, OC'($urandom), int'($urandom_range(0, 40)),
                         int'($urandom_range(0, 40)), int'($urandom_range(0, 40)), 300);
        end

        // sync while ch0 is in its page-2 frame
        base_m[0] = 32'h0200; wc_m[0] = 32'h10; pc_m[0] = 4;
        load_cfg();
        frame_period = 24'd60;
        enable_mask = 3'b001;
        do_reset();
        for (int f = 1; f <= 3; f++) begin
            goto(60 * f);
            check($sformatf("sync_pre_start%0d", f), 64'(chan_if.channel_start), 64'd1);
            if (f < 3) begin
                goto(60 * f + 20);
                chan_if.channel_done = 3'b001;
                tick();
                chan_if.channel_done = '0;
            end
        end
        check("sync_page_before", 64'(chan_if.page_indices[7:0]), 64'd2);
        check("sync_addr_before", 64'(chan_if.start_addresses[15:0]), 64'h0220);
        goto(185);
        sync = 1'b1;
        tick();
        sync = 1'b0;
        check("sync_page_now", 64'(chan_if.page_indices[7:0]), 64'd0);
        check("sync_state_run", 64'(state), 64'd1);
        goto(200);
        chan_if.channel_done = 3'b001;
        tick();
        chan_if.channel_done = '0;
        goto(202);
        check("sync_state_wait", 64'(state), 64'd0);
        check("sync_page_after", 64'(chan_if.page_indices[7:0]), 64'd0);
        check("sync_addr_after", 64'(chan_if.start_addresses[15:0]), 64'h0200);
        goto(240);
        check("sync_old_slot_idle", 64'(chan_if.channel_start), 64'd0);
        goto(246);
        check("sync_new_slot_start", 64'(chan_if.channel_start), 64'd1);
        check("sync_new_slot_addr", 64'(chan_if.start_addresses[15:0]), 64'h0200);

        // async reset in the middle of a frame
        for (int i = 0; i < OC; i++) begin
            base_m[i] = int'($urandom % 65536); wc_m[i] = int'($urandom_range(1, 65535));
            pc_m[i] = 3;
        end
        load_cfg();
        frame_period = 24'd40;
        enable_mask = 3'b111;
        do_reset();
        for (int f = 1; f <= 3; f++) begin
            goto(40 * f);
            check($sformatf("rst_pre_start%0d", f), 64'(chan_if.channel_start), 64'd7);
            if (f < 3) begin
                goto(40 * f + 5);
                chan_if.channel_done = 3'b111;
                tick();
                chan_if.channel_done = '0;
            end
        end
        check("rst_pages_before", 64'(chan_if.page_indices), 64'h020202);
        #2 rst = 1'b1;
        #1;
        check("rst_start", 64'(chan_if.channel_start), 64'd0);
        check("rst_state", 64'(state), 64'd0);
        check("rst_overrun", 64'(overrun_count), 64'd0);
        check("rst_pages", 64'(chan_if.page_indices), 64'd0);
        check("rst_addr", 64'(chan_if.start_addresses), 64'(base_addresses));
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        for (int c = 0; c <= 40; c++) begin
            check($sformatf("rst_release_start@%0d", c), 64'(chan_if.channel_start),
                  64'((c == 40) ? 7 : 0));
            if (c < 40) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
